// File: rtl/x4_spi_slave.sv
// x4_spi_slave: SPI mode-0 slave emulating the X4 register interface over a 2**ADDR_W x 8 register file.
// Define X4_SPI_FIFO_EN to map FIFO_ADDR onto a 16-deep emulated data FIFO.
module x4_spi_slave #(
    parameter int ADDR_W = 7,
    parameter int SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0] FIFO_ADDR = 7'h7F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              reg_wr_stb,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    input  logic              loc_wr_en,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    output logic [7:0]        loc_rdata,
    output logic              busy,
    output logic              frame_err,
    input  logic              loc_fifo_wr,
    input  logic [7:0]        loc_fifo_data,
    output logic [4:0]        fifo_level
);
    localparam int DEPTH = 2**ADDR_W;
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [2:0] pin_s;
    logic sclk_prev_q, cs_prev_q, sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_in_q, shift_in_d;
    logic [7:0] byte_in, shift_out_q, shift_out_d, shift_out_nx, snap_data;
    logic [ADDR_W-1:0] addr_q, addr_d, snap_addr, wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d, loc_rdata_q;
    logic miso_q, miso_d, wr_stb_q, wr_stb_d, frame_err_q, frame_err_d, snap, hold;
    logic [7:0] mem_q [DEPTH];
    // cs synchroniser resets low so a frame already in progress at reset release never looks like a falling edge
    assign sync_d = {sync_q[SYNC_STAGES-2:0], {spi_sclk, spi_cs, spi_mosi}};
    assign pin_s = sync_q[SYNC_STAGES-1];
    assign sclk_rise = pin_s[2] & ~sclk_prev_q;
    assign sclk_fall = ~pin_s[2] & sclk_prev_q;
    assign cs_rise = pin_s[1] & ~cs_prev_q;
    assign cs_fall = ~pin_s[1] & cs_prev_q;
    assign byte_in = {shift_in_q, pin_s[0]};
    assign shift_out_d = snap ? snap_data : shift_out_nx;
`ifdef X4_SPI_FIFO_EN
    logic [7:0] fifo_q [16];
    logic [3:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [4:0] level_q, level_d;
    logic pop, push;
    assign pop = snap && (snap_addr == FIFO_ADDR) && (level_q != 5'd0);
    assign push = loc_fifo_wr && ((level_q != 5'd16) || pop);
    assign rd_ptr_d = rd_ptr_q + {3'd0, pop};
    assign wr_ptr_d = wr_ptr_q + {3'd0, push};
    assign level_d = level_q + {4'd0, push} - {4'd0, pop};
    assign hold = addr_q == FIFO_ADDR;
    assign snap_data = (snap_addr != FIFO_ADDR) ? mem_q[snap_addr] : (level_q != 5'd0) ? fifo_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;
    always_ff @(posedge clk)
        if (push) fifo_q[wr_ptr_q] <= loc_fifo_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q <= level_d;
        end
`else
    logic unused_fifo;
    assign unused_fifo = ^{loc_fifo_wr, loc_fifo_data, FIFO_ADDR};
    assign hold = 1'b0;
    assign snap_data = mem_q[snap_addr];
    assign fifo_level = 5'd0;
`endif
    always_comb begin
        state_d = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_in_d = shift_in_q;
        shift_out_nx = shift_out_q;
        addr_d = addr_q;
        miso_d = miso_q;
        wr_stb_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        frame_err_d = 1'b0;
        snap = 1'b0;
        snap_addr = addr_q;
        if (state_q == IDLE) begin
            miso_d = 1'b0;
            bit_cnt_d = 3'd0;
            state_d = cs_fall ? CMD : IDLE;
        end else if (cs_rise) begin
            state_d = IDLE;
            miso_d = 1'b0;
            bit_cnt_d = 3'd0;
            frame_err_d = bit_cnt_q != 3'd0;
        end else if (sclk_rise) begin
            shift_in_d = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (state_q == CMD) begin
                    addr_d = byte_in[ADDR_W-1:0];
                    state_d = byte_in[7] ? RDATA : WDATA;
                    snap = byte_in[7];
                    snap_addr = byte_in[ADDR_W-1:0];
                end else if (state_q == WDATA) begin
                    wr_stb_d = !hold;
                    wr_addr_d = hold ? wr_addr_q : addr_q;
                    wr_data_d = hold ? wr_data_q : byte_in;
                    addr_d = addr_q + 1'b1;
                end else begin
                    addr_d = hold ? addr_q : addr_q + 1'b1;
                    snap = 1'b1;
                    snap_addr = addr_d;
                end
            end
        end else if (sclk_fall && state_q == RDATA) begin
            miso_d = shift_out_q[7];
            shift_out_nx = {shift_out_q[6:0], 1'b0};
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q <= 1'b0;
            bit_cnt_q <= '0;
            shift_in_q <= '0;
            shift_out_q <= '0;
            addr_q <= '0;
            miso_q <= 1'b0;
            wr_stb_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            frame_err_q <= 1'b0;
            loc_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            sclk_prev_q <= pin_s[2];
            cs_prev_q <= pin_s[1];
            bit_cnt_q <= bit_cnt_d;
            shift_in_q <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q <= addr_d;
            miso_q <= miso_d;
            wr_stb_q <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            frame_err_q <= frame_err_d;
            loc_rdata_q <= mem_q[loc_addr];
        end
    // SPI write is applied after the local write so it wins a same-address collision
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (loc_wr_en) mem_q[loc_addr] <= loc_wdata;
            if (wr_stb_d) mem_q[wr_addr_d] <= wr_data_d;
        end
    assign spi_miso = miso_q;
    assign reg_wr_stb = wr_stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign loc_rdata = loc_rdata_q;
    assign busy = state_q != IDLE;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_x4_spi_slave.sv
// tb_x4_spi_slave: randomized scoreboard bench for x4_spi_slave against a byte-level register/FIFO model.
// Honours X4_SPI_FIFO_EN the same way the design does.
module tb_x4_spi_slave;
    localparam int HALF = 6;
    logic clk = 1'b0, rst_n = 1'b0;
    logic spi_sclk = 1'b0, spi_cs = 1'b1, spi_mosi = 1'b0, spi_miso;
    logic reg_wr_stb, busy, frame_err;
    logic [6:0] reg_wr_addr, loc_addr = '0;
    logic [7:0] reg_wr_data, loc_wdata = '0, loc_rdata, loc_fifo_data = '0;
    logic loc_wr_en = 1'b0, loc_fifo_wr = 1'b0;
    logic [4:0] fifo_level;

    x4_spi_slave dut (
        .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .loc_wr_en(loc_wr_en), .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_rdata(loc_rdata),
        .busy(busy), .frame_err(frame_err), .loc_fifo_wr(loc_fifo_wr), .loc_fifo_data(loc_fifo_data),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, exp_ferr = 0;
    logic [7:0] model [128];
    logic [7:0] mfifo[$], tx_q[$], exp_rx_q[$], got_rx_q[$], exp_loc_q[$];
    logic [14:0] exp_wr_q[$];
    logic probe = 1'b0;
    logic [14:0] mon_e;
    logic [7:0] mon_g;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_wr_stb) begin
            if (exp_wr_q.size() == 0) check("wr_unexpected", {reg_wr_addr, reg_wr_data}, 0);
            else begin
                mon_e = exp_wr_q.pop_front();
                check("wr_commit", {reg_wr_addr, reg_wr_data}, mon_e);
            end
        end
        if (frame_err) begin
            check("frame_err_expected", int'(exp_ferr > 0), 1);
            if (exp_ferr > 0) exp_ferr--;
        end
        while (got_rx_q.size() != 0) begin
            mon_g = got_rx_q.pop_front();
            if (exp_rx_q.size() == 0) check("rx_unexpected", mon_g, 0);
            else check("miso_byte", mon_g, exp_rx_q.pop_front());
        end
        if (probe) check("loc_rdata", loc_rdata, exp_loc_q.pop_front());
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mread(inout logic [6:0] p, output logic [7:0] v);
`ifdef X4_SPI_FIFO_EN
        if (p == 7'h7F) begin
            v = 8'h00;
            if (mfifo.size() != 0) v = mfifo.pop_front();
            return;
        end
`endif
        v = model[p];
        p = p + 7'd1;
    endtask

    task automatic mwrite(inout logic [6:0] p, input logic [7:0] v);
`ifdef X4_SPI_FIFO_EN
        if (p != 7'h7F)
`endif
        begin
            model[p] = v;
            exp_wr_q.push_back({p, v});
        end
        p = p + 7'd1;
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            clks(HALF);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            clks(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic rd, input logic [6:0] a, input int n);
        logic [7:0] rx, v, d;
        logic [6:0] p;
        p = a;
        v = '0;
        spi_cs = 1'b0;
        clks(HALF);
        check("busy_in_frame", busy, 1);
        exp_rx_q.push_back(8'h00);
        spi_byte({rd, a}, 8, rx);
        got_rx_q.push_back(rx);
        if (rd) mread(p, v);
        for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            if (tx_q.size() != 0) d = tx_q.pop_front();
            if (rd) begin
                exp_rx_q.push_back(v);
                mread(p, v);
            end else begin
                exp_rx_q.push_back(8'h00);
                mwrite(p, d);
            end
            spi_byte(d, 8, rx);
            got_rx_q.push_back(rx);
        end
        clks(HALF);
        spi_cs = 1'b1;
        clks(HALF);
    endtask

    task automatic loc_write(input logic [6:0] a, input logic [7:0] d);
        loc_addr = a;
        loc_wdata = d;
        loc_wr_en = 1'b1;
        clks(1);
        loc_wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic loc_read(input logic [6:0] a);
        loc_addr = a;
        exp_loc_q.push_back(model[a]);
        clks(1);
        probe = 1'b1;
        clks(1);
        probe = 1'b0;
    endtask

    task automatic fifo_push(input logic [7:0] d);
        loc_fifo_data = d;
        loc_fifo_wr = 1'b1;
        clks(1);
        loc_fifo_wr = 1'b0;
`ifdef X4_SPI_FIFO_EN
        if (mfifo.size() < 16) mfifo.push_back(d);
`endif
    endtask

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic [6:0] p;
        logic hit;
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        clks(3);
        check("reset_outputs", {spi_miso, reg_wr_stb, reg_wr_addr, reg_wr_data, loc_rdata, busy, frame_err, fifo_level}, 0);
        rst_n = 1'b1;
        clks(4);
        // write 05 <- A5, then read it back locally
        tx_q.push_back(8'hA5);
        frame(1'b0, 7'h05, 1);
        loc_read(7'h05);
`ifndef X4_SPI_FIFO_EN
        // read burst wrapping 7F -> 00
        loc_write(7'h7F, 8'h11);
        loc_write(7'h00, 8'h22);
        frame(1'b1, 7'h7F, 2);
`endif
        // cs rises after 3 data bits of a write to 10
        loc_write(7'h10, 8'h5C);
        spi_cs = 1'b0;
        clks(HALF);
        exp_rx_q.push_back(8'h00);
        spi_byte(8'h10, 8, rx);
        got_rx_q.push_back(rx);
        spi_byte(8'hFF, 3, rx);
        clks(HALF);
        exp_ferr++;
        spi_cs = 1'b1;
        clks(HALF);
        loc_read(7'h10);
        // SPI commit and local write to 20 land in the same clk
        spi_cs = 1'b0;
        clks(HALF);
        exp_rx_q.push_back(8'h00);
        spi_byte(8'h20, 8, rx);
        got_rx_q.push_back(rx);
        p = 7'h20;
        mwrite(p, 8'h33);
        spi_byte(8'h33, 7, rx);
        spi_mosi = 1'b1;
        clks(HALF);
        loc_addr = 7'h20;
        loc_wdata = 8'h44;
        loc_wr_en = 1'b1;
        spi_sclk = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            clks(1);
            hit = reg_wr_stb;
        end
        loc_wr_en = 1'b0;
        check("collision_commit_seen", hit, 1);
        clks(HALF);
        spi_sclk = 1'b0;
        clks(HALF);
        spi_cs = 1'b1;
        clks(HALF);
        loc_read(7'h20);
        // reset mid read frame, released with cs still low
        loc_write(7'h05, 8'h9E);
        spi_cs = 1'b0;
        clks(HALF);
        spi_byte(8'h85, 5, rx);
        rst_n = 1'b0;
        clks(3);
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
        mfifo.delete();
        rst_n = 1'b1;
        spi_byte(8'hFF, 8, rx);
        check("post_reset_miso", rx, 0);
        check("post_reset_busy", busy, 0);
        spi_cs = 1'b1;
        clks(HALF);
        loc_read(7'h05);
        frame(1'b0, 7'h30, 2);
        frame(1'b1, 7'h30, 2);
`ifdef X4_SPI_FIFO_EN
        fifo_push(8'h01);
        fifo_push(8'h02);
        fifo_push(8'h03);
        check("fifo_level_3", fifo_level, 3);
        frame(1'b1, 7'h7F, 4);
        check("fifo_level_drained", fifo_level, 0);
        for (int i = 0; i < 18; i++) fifo_push(8'(i + 8'h40));
        check("fifo_level_full", fifo_level, 16);
        frame(1'b1, 7'h7F, 17);
        check("fifo_level_empty", fifo_level, 0);
`else
        fifo_push(8'h01);
        check("fifo_level_disabled", fifo_level, 0);
`endif
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: loc_write(7'($urandom), 8'($urandom));
                1: frame(1'b0, 7'($urandom), int'($urandom_range(1, 4)));
                2: frame(1'b1, 7'($urandom), int'($urandom_range(1, 4)));
                3: fifo_push(8'($urandom));
                default: loc_read(7'($urandom));
            endcase
        end
        for (int i = 0; i < 4; i++) loc_read(7'($urandom));
        clks(20);
        check("pending_writes", exp_wr_q.size(), 0);
        check("pending_frame_err", exp_ferr, 0);
        check("pending_rx", exp_rx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
